// File: rtl/fir_channel_scheduler.sv
// Round-robin front end that shares one FIR MAC engine among CHANNELS sample streams.
// Defining FIR_SCHED_TIMEOUT_EN adds a WAIT watchdog that returns an error result after TIMEOUT cycles.
module fir_channel_scheduler #(
    parameter int DATA_WIDTH = 12,
    parameter int TAPS       = 16,
    parameter int CHANNELS   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic [CHANNELS-1:0]              ch_valid,
    output logic [CHANNELS-1:0]              ch_ready,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   ch_sample,
    input  logic [2*CHANNELS-1:0]            ch_mode,
    output logic                             fir_start,
    output logic [1:0]                       fir_mode,
    output logic [TAPS*DATA_WIDTH-1:0]       fir_buffer,
    input  logic [DATA_WIDTH-1:0]            fir_result,
    input  logic                             fir_done,
    output logic                             res_valid,
    input  logic                             res_ready,
    output logic [DATA_WIDTH-1:0]            res_data,
    output logic [$clog2(CHANNELS)-1:0]      res_ch,
    output logic                             res_err,
    output logic                             busy
);
    localparam int CW = $clog2(CHANNELS);
    localparam int LW = TAPS * DATA_WIDTH;

    if (CHANNELS < 2 || (CHANNELS & (CHANNELS - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
        $error("fir_channel_scheduler: CHANNELS must be a power of two >= 2 and TIMEOUT >= 1");
    end

    // state | meaning
    // IDLE  | nothing pending
    // GRANT | round-robin pick, ch_ready pulse, delay line shift
    // START | one-cycle engine start
    // WAIT  | engine running; buffer and mode held
    // OUT   | result offered downstream
    typedef enum logic [2:0] {IDLE, GRANT, START, WAIT, OUT} state_t;
    state_t state, state_nx;

    logic [LW-1:0]          line_q [CHANNELS];
    logic [CW-1:0]          rr_ptr;
    logic [CW-1:0]          gnt_q;
    logic [CW-1:0]          grant_ch;
    logic [CW-1:0]          cand;
    logic                   grant_hit;
    logic [1:0]             mode_q;
    logic [DATA_WIDTH-1:0]  data_q;
    logic                   err_q;
    logic                   timeout;

    // Search starts one past the last grant; CW-bit addition wraps naturally.
    always_comb begin
        grant_hit = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        for (int i = 1; i <= CHANNELS; i++) begin
            cand = rr_ptr + CW'(i);
            if (!grant_hit && ch_valid[cand]) begin
                grant_hit = 1'b1;
                grant_ch  = cand;
            end
        end
    end

`ifdef FIR_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (state == START) begin
            wait_cnt <= '0;
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt + TW'(1);
        end
    end

    assign timeout = (state == WAIT) && !fir_done && (wait_cnt == TW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|ch_valid) state_nx = GRANT;
            GRANT:   state_nx = grant_hit ? START : IDLE;
            START:   state_nx = WAIT;
            WAIT:    if (fir_done || timeout) state_nx = OUT;
            OUT:     if (res_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ch_ready = '0;
        if (state == GRANT && grant_hit) ch_ready[grant_ch] = 1'b1;
        fir_start = (state == START);
        res_valid = (state == OUT);
        busy      = (state != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) line_q[c] <= '0;
            rr_ptr <= CW'(CHANNELS - 1);
            gnt_q  <= '0;
            mode_q <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == GRANT && grant_hit) begin
                line_q[grant_ch] <= {line_q[grant_ch][LW-DATA_WIDTH-1:0],
                                     ch_sample[int'(grant_ch)*DATA_WIDTH +: DATA_WIDTH]};
                mode_q <= ch_mode[int'(grant_ch)*2 +: 2];
                gnt_q  <= grant_ch;
                rr_ptr <= grant_ch;
            end
            if (state == WAIT && fir_done) begin
                data_q <= fir_result;
                err_q  <= 1'b0;
            end else if (timeout) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end
        end
    end

    // Only the granted line can shift and no grant happens before OUT, so the mux is stable through WAIT.
    assign fir_mode   = mode_q;
    assign fir_buffer = line_q[gnt_q];
    assign res_data   = data_q;
    assign res_ch     = gnt_q;
    assign res_err    = err_q;

endmodule

// File: tb/tb_fir_channel_scheduler.sv
// Randomized bench for fir_channel_scheduler with a behavioural engine and a per-channel history model.
module tb_fir_channel_scheduler;
    localparam int DW = 12;
    localparam int TAPS = 16;
    localparam int CH = 4;
    localparam int TIMEOUT = 64;
    localparam int CW = 2;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic [CH-1:0]        ch_valid;
    logic [CH-1:0]        ch_ready;
    logic [CH*DW-1:0]     ch_sample;
    logic [2*CH-1:0]      ch_mode;
    logic                 fir_start;
    logic [1:0]           fir_mode;
    logic [TAPS*DW-1:0]   fir_buffer;
    logic [DW-1:0]        fir_result = '0;
    logic                 fir_done = 1'b0;
    logic                 res_valid;
    logic                 res_ready;
    logic [DW-1:0]        res_data;
    logic [CW-1:0]        res_ch;
    logic                 res_err;
    logic                 busy;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    fir_channel_scheduler #(.DATA_WIDTH(DW), .TAPS(TAPS), .CHANNELS(CH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_sample(ch_sample), .ch_mode(ch_mode),
        .fir_start(fir_start), .fir_mode(fir_mode), .fir_buffer(fir_buffer),
        .fir_result(fir_result), .fir_done(fir_done),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_ch(res_ch), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Offered stimulus and reference history (hist[c][0] is newest)
    logic [CH-1:0] vld;
    logic [DW-1:0] smp [CH];
    logic [1:0]    md  [CH];
    int            hist [CH][TAPS];
    int            ptr;

    function automatic int coef(input int m, input int i);
        case (m)
            0:       return 100 + 20 * i;
            1:       return (i % 2 == 0) ? 400 : -400;
            2:       return (i < 8) ? 60 * i : -60 * (15 - i);
            default: return 0;
        endcase
    endfunction

    // Behavioural engine: done pulse TAPS+1 cycles after the start cycle
    logic [TAPS*DW-1:0] eng_buf = '0;
    logic [1:0]         eng_mode = '0;
    int                 eng_cnt = 0;
    bit                 eng_en = 1'b1;

    function automatic logic [DW-1:0] eng_calc(input logic [TAPS*DW-1:0] b, input logic [1:0] m);
        int acc;
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += int'($signed(b[i*DW +: DW])) * coef(int'(m), i);
        return DW'(acc >>> 12);
    endfunction

    always @(posedge clk) begin
        fir_done <= 1'b0;
        if (eng_cnt != 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1 && eng_en) begin
                fir_done   <= 1'b1;
                fir_result <= eng_calc(eng_buf, eng_mode);
            end
        end
        if (fir_start) begin
            eng_cnt  <= TAPS;
            eng_buf  <= fir_buffer;
            eng_mode <= fir_mode;
        end
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        ch_valid = vld;
        for (int c = 0; c < CH; c++) begin
            ch_sample[c*DW +: DW] = smp[c];
            ch_mode[2*c +: 2]     = md[c];
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < TAPS; i++) hist[c][i] = 0;
        ptr = CH - 1;
    endtask

    function automatic int exp_grant();
        for (int i = 1; i <= CH; i++) begin
            if (vld[(ptr + i) % CH]) return (ptr + i) % CH;
        end
        return 0;
    endfunction

    function automatic logic [TAPS*DW-1:0] pack(input int c);
        logic [TAPS*DW-1:0] v;
        v = '0;
        for (int i = 0; i < TAPS; i++) v[i*DW +: DW] = DW'(hist[c][i]);
        return v;
    endfunction

    function automatic logic [DW-1:0] model_res(input int c, input int m);
        int acc;
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += hist[c][i] * coef(m, i);
        return DW'(acc >>> 12);
    endfunction

    task automatic wait_grant(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 10 && !ok; t++) begin
            @(negedge clk);
            if (ch_ready != '0) ok = 1'b1;
        end
        if (!ok) chk("grant_wait", 0, 1);
    endtask

    task automatic txn(input int stall);
        int g, m, gcyc;
        bit ok, quiet;
        logic [DW-1:0] expd;
        g = exp_grant();
        wait_grant(ok);
        if (!ok) return;
        chk("ch_ready", ch_ready, 1 << g);
        gcyc = cyc;
        m = int'(md[g]);
        for (int i = TAPS - 1; i > 0; i--) hist[g][i] = hist[g][i-1];
        hist[g][0] = int'($signed(smp[g]));
        ptr = g;
        @(negedge clk);
        vld[g] = 1'b0;
        smp[g] = DW'($urandom);
        drive();
        chk("fir_start", fir_start, 1);
        chk("fir_mode", fir_mode, m);
        chk("fir_buffer", fir_buffer, pack(g));
        res_ready = (stall == 0);
        expd = model_res(g, m);
        ok = 1'b0;
        for (int t = 0; t < TAPS + 10 && !ok; t++) begin
            @(negedge clk);
            if (res_valid) ok = 1'b1;
        end
        if (!ok) begin
            chk("res_valid_wait", 0, 1);
            return;
        end
        chk("res_latency", cyc - gcyc, TAPS + 3);
        chk("res_data", res_data, expd);
        chk("res_ch", res_ch, g);
        chk("res_err", res_err, 0);
        if (stall > 0) begin
            quiet = 1'b1;
            for (int k = 0; k < stall; k++) begin
                @(negedge clk);
                if (!res_valid || res_data !== expd || res_ch !== CW'(g) || ch_ready != '0 || fir_start)
                    quiet = 1'b0;
            end
            chk("stall_hold", quiet, 1);
            res_ready = 1'b1;
        end
        @(negedge clk);
        chk("res_valid_drop", res_valid, 0);
        chk("busy_idle", busy, 0);
    endtask

    initial begin
        bit ok, quiet;
        int gcyc;
        vld = '0;
        for (int c = 0; c < CH; c++) begin
            smp[c] = '0;
            md[c] = '0;
        end
        res_ready = 1'b0;
        drive();
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_outputs", {ch_ready, fir_start, fir_mode, res_valid, res_data, res_ch, res_err, busy}, 0);
        chk("rst_buffer", fir_buffer, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single channel ramp, LPF
        for (int s = 1; s <= 16; s++) begin
            vld = 4'b0001;
            smp[0] = DW'(s);
            md[0] = 2'b00;
            drive();
            txn(0);
        end

        // All channels requesting, random data and modes (including 11)
        for (int k = 0; k < 8; k++) begin
            vld = '1;
            for (int c = 0; c < CH; c++) md[c] = 2'($urandom_range(0, 3));
            drive();
            txn(0);
        end

        // Back-pressure
        for (int k = 0; k < 4; k++) begin
            vld = CH'($urandom_range(1, (1 << CH) - 1));
            drive();
            txn((k == 0) ? 10 : int'($urandom_range(1, 6)));
        end

        // Delay-line isolation between ch1 (full scale) and ch2 (zero)
        for (int k = 0; k < 32; k++) begin
            if (k % 2 == 0) begin
                vld = 4'b0010;
                smp[1] = 12'h7FF;
                md[1] = 2'($urandom_range(0, 2));
            end else begin
                vld = 4'b0100;
                smp[2] = '0;
                md[2] = 2'($urandom_range(0, 3));
            end
            drive();
            txn(0);
        end

        // Request withdrawn while in GRANT: no grant, pointer and history untouched
        vld = '0;
        drive();
        @(negedge clk);
        vld = 4'b1000;
        drive();
        @(negedge clk);
        vld = '0;
        drive();
        @(negedge clk);
        chk("withdraw_idle", {busy, ch_ready}, 0);

        // Random mix
        for (int k = 0; k < 24; k++) begin
            vld = CH'($urandom_range(1, (1 << CH) - 1));
            for (int c = 0; c < CH; c++) md[c] = 2'($urandom_range(0, 3));
            drive();
            txn(int'($urandom_range(0, 3)));
        end

        // Reset mid-WAIT
        vld = 4'b0100;
        drive();
        wait_grant(ok);
        @(negedge clk);
        chk("rst_test_start", fir_start, 1);
        vld = '0;
        drive();
        repeat (7) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_outputs", {ch_ready, fir_start, fir_mode, res_valid, res_data, res_ch, res_err, busy}, 0);
        chk("midrst_buffer", fir_buffer, 0);
        model_reset();
        reset_n = 1'b1;
        quiet = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (res_valid || busy) quiet = 1'b0;
        end
        chk("late_done_ignored", quiet, 1);

        // Fairness from reset: expect 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            vld = '1;
            drive();
            chk("rr_order_expect", exp_grant(), k % CH);
            txn(0);
        end

        // Engine never finishes
        eng_en = 1'b0;
        vld = 4'b0001;
        drive();
        res_ready = 1'b1;
        wait_grant(ok);
        gcyc = cyc;
        @(negedge clk);
        vld = '0;
        drive();
`ifdef FIR_SCHED_TIMEOUT_EN
        ok = 1'b0;
        for (int t = 0; t < TIMEOUT + 20 && !ok; t++) begin
            @(negedge clk);
            if (res_valid) ok = 1'b1;
        end
        chk("timeout_valid", ok, 1);
        chk("timeout_latency", cyc - gcyc, TIMEOUT + 2);
        chk("timeout_err", res_err, 1);
        chk("timeout_data", res_data, 0);
`else
        repeat (200) @(negedge clk);
        chk("stuck_busy", busy, 1);
        chk("stuck_no_result", res_valid, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
